// File: rtl/aes_inv_roundkey_gen_pkg.sv
// Shared types, constants and helper functions for the inverse round-key generator.
//   aes_mode_t      : key size selector (00 AES-128, 01 AES-192, 10 AES-256, 11 illegal)
//   fsm_state_t     : controller states, also exported on the debug port
//   RCON            : round constants, indexed 1..10
//   SBOX            : forward AES S-box, indexed by the input byte
//   nk_of / nr_of   : key length in words / number of rounds for a mode
//   inv_mixcolumns  : InvMixColumns over a 128-bit state (column 0 in [127:96])
package aes_inv_roundkey_gen_pkg;

  typedef enum logic [1:0] {
    MODE_128 = 2'b00,
    MODE_192 = 2'b01,
    MODE_256 = 2'b10,
    MODE_BAD = 2'b11
  } aes_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_EXPAND = 2'd2,
    ST_STREAM = 2'd3
  } fsm_state_t;

  localparam int NUM_WORDS = 60;

  localparam logic [1:10][7:0] RCON = {
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Element 0 sits in the most significant byte, so SBOX[x] is S(x).
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [3:0] nk_of(input aes_mode_t m);
    case (m)
      MODE_192: return 4'd6;
      MODE_256: return 4'd8;
      default:  return 4'd4;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input aes_mode_t m);
    case (m)
      MODE_192: return 4'd12;
      MODE_256: return 4'd14;
      default:  return 4'd10;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One column: multiply by the circulant matrix {0e,0b,0d,09}.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] s   [4];
    logic [7:0] m9  [4];
    logic [7:0] m11 [4];
    logic [7:0] m13 [4];
    logic [7:0] m14 [4];
    logic [7:0] x2, x4, x8;
    for (int k = 0; k < 4; k++) begin
      s[k]   = c[31-8*k -: 8];
      x2     = xtime(s[k]);
      x4     = xtime(x2);
      x8     = xtime(x4);
      m9[k]  = x8 ^ s[k];
      m11[k] = x8 ^ x2 ^ s[k];
      m13[k] = x8 ^ x4 ^ s[k];
      m14[k] = x8 ^ x4 ^ x2;
    end
    return {m14[0] ^ m11[1] ^ m13[2] ^ m9[3],
            m9[0]  ^ m14[1] ^ m11[2] ^ m13[3],
            m13[0] ^ m9[1]  ^ m14[2] ^ m11[3],
            m11[0] ^ m13[1] ^ m9[2]  ^ m14[3]};
  endfunction

  function automatic logic [127:0] inv_mixcolumns(input logic [127:0] st);
    return {inv_mix_col(st[127:96]), inv_mix_col(st[95:64]),
            inv_mix_col(st[63:32]),  inv_mix_col(st[31:0])};
  endfunction

endpackage

// File: rtl/aes_inv_roundkey_gen_subword.sv
// SubWord: four parallel forward S-box lookups, purely combinational.
//   i_word : 32-bit input word
//   o_word : byte-wise S-box substitution of i_word
module aes_inv_roundkey_gen_subword
  import aes_inv_roundkey_gen_pkg::*;
(
  input  logic [31:0] i_word,
  output logic [31:0] o_word
);

  assign o_word[31:24] = SBOX[i_word[31:24]];
  assign o_word[23:16] = SBOX[i_word[23:16]];
  assign o_word[15:8]  = SBOX[i_word[15:8]];
  assign o_word[7:0]   = SBOX[i_word[7:0]];

endmodule

// File: rtl/aes_inv_roundkey_gen.sv
// Decryption-side AES round-key generator. A start pulse captures the key, the
// schedule is expanded one word per cycle into a 60x32 word store, and the round
// keys are then streamed from round Nr down to round 0.
//   clk, rst            : clock, synchronous active-high reset
//   start, mode, key_in : start pulse with key size and key (w[0] = MS word)
//   busy, err           : job in progress / 1-cycle illegal-mode pulse
//   key_valid/key_ready : output handshake
//   round_key/round_idx/last : presented key, its round number, round-0 flag
//   dbg_state           : current controller state
// Handshake: round_key, round_idx and last are meaningful only while key_valid
// is high; they stay constant until the cycle after key_valid & key_ready, and
// key_ready is don't-care while key_valid is low.
module aes_inv_roundkey_gen
  import aes_inv_roundkey_gen_pkg::*;
#(
  parameter bit EQ_INV = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   mode,
  input  logic [255:0] key_in,
  output logic         busy,
  output logic         err,
  output logic         key_valid,
  input  logic         key_ready,
  output logic [127:0] round_key,
  output logic [3:0]   round_idx,
  output logic         last,
  output fsm_state_t   dbg_state
);

  fsm_state_t   r_state;
  aes_mode_t    r_mode;
  logic [5:0]   r_i;       // index of the word being generated
  logic [2:0]   r_kpos;    // r_i mod Nk, kept incrementally to avoid a divider
  logic [3:0]   r_rc;      // r_i / Nk, valid when r_kpos == 0
  logic [3:0]   r_round;
  logic         r_busy;
  logic         r_err;
  logic         r_valid;
  logic         r_last;
  logic [127:0] r_key;
  logic [31:0]  r_w [NUM_WORDS];

  aes_mode_t    w_mode_in;
  logic         w_start_ok;
  logic [3:0]   w_nk_in;
  logic [3:0]   w_nk;
  logic [3:0]   w_nr;
  logic [5:0]   w_last_i;
  logic [255:0] w_key_aligned;
  logic [31:0]  w_prev;
  logic [31:0]  w_back;
  logic         w_rot;
  logic         w_sub_only;
  logic [31:0]  w_sub_in;
  logic [31:0]  w_sub_out;
  logic [31:0]  w_temp;
  logic [31:0]  w_new;
  logic [3:0]   w_next_round;
  logic [127:0] w_rk_raw;
  logic [127:0] w_next_key;

  assign w_mode_in  = aes_mode_t'(mode);
  assign w_start_ok = start && (w_mode_in != MODE_BAD);
  assign w_nk_in    = nk_of(w_mode_in);
  assign w_nk       = nk_of(r_mode);
  assign w_nr       = nr_of(r_mode);
  assign w_last_i   = {w_nr, 2'b11};

  // Left-align the key field so w[j] is always bits [255-32j -: 32].
  always_comb begin
    w_key_aligned = key_in;
    case (w_mode_in)
      MODE_128: w_key_aligned = {key_in[127:0], 128'h0};
      MODE_192: w_key_aligned = {key_in[191:0], 64'h0};
      default:  w_key_aligned = key_in;
    endcase
  end

  // Expansion datapath: one S-box bank shared by the RotWord and SubWord-only paths.
  assign w_prev     = r_w[r_i - 6'd1];
  assign w_back     = r_w[r_i - {2'b00, w_nk}];
  assign w_rot      = (r_kpos == 3'd0);
  assign w_sub_only = (r_mode == MODE_256) && (r_kpos == 3'd4);
  assign w_sub_in   = w_rot ? {w_prev[23:0], w_prev[31:24]} : w_prev;

  aes_inv_roundkey_gen_subword u_subword (
    .i_word (w_sub_in),
    .o_word (w_sub_out)
  );

  always_comb begin
    w_temp = w_prev;
    if (w_rot) begin
      w_temp = w_sub_out ^ {RCON[r_rc], 24'h0};
    end else if (w_sub_only) begin
      w_temp = w_sub_out;
    end
  end

  assign w_new = w_back ^ w_temp;

  // Next key to present after a handshake; rounds Nr and 0 are never transformed.
  assign w_next_round = r_round - 4'd1;
  assign w_rk_raw     = {r_w[{w_next_round, 2'd0}], r_w[{w_next_round, 2'd1}],
                         r_w[{w_next_round, 2'd2}], r_w[{w_next_round, 2'd3}]};
  assign w_next_key   = (EQ_INV && (w_next_round != 4'd0)) ? inv_mixcolumns(w_rk_raw)
                                                            : w_rk_raw;

  // Word store. The key words are written when the start is accepted, so the
  // LOAD cycle only primes the expansion counters.
  always_ff @(posedge clk) begin
    if (w_start_ok) begin
      for (int j = 0; j < 8; j++) begin
        if (j < int'(w_nk_in)) begin
          r_w[j] <= w_key_aligned[255-32*j -: 32];
        end
      end
    end else if (r_state == ST_EXPAND) begin
      r_w[r_i] <= w_new;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_mode  <= MODE_128;
      r_i     <= 6'd0;
      r_kpos  <= 3'd0;
      r_rc    <= 4'd0;
      r_round <= 4'd0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_key   <= 128'h0;
    end else begin
      r_err <= start && (w_mode_in == MODE_BAD);
      if (w_start_ok) begin
        // Accepted start in any state aborts the current job.
        r_state <= ST_LOAD;
        r_mode  <= w_mode_in;
        r_busy  <= 1'b1;
        r_valid <= 1'b0;
        r_last  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
          end
          ST_LOAD: begin
            r_i     <= {2'b00, w_nk};
            r_kpos  <= 3'd0;
            r_rc    <= 4'd1;
            r_state <= ST_EXPAND;
          end
          ST_EXPAND: begin
            if (r_i == w_last_i) begin
              // The final word is still in flight, so take it from the datapath.
              r_state <= ST_STREAM;
              r_round <= w_nr;
              r_valid <= 1'b1;
              r_last  <= 1'b0;
              r_key   <= {r_w[{w_nr, 2'd0}], r_w[{w_nr, 2'd1}], r_w[{w_nr, 2'd2}], w_new};
            end else begin
              r_i <= r_i + 6'd1;
              if (r_kpos == (w_nk[2:0] - 3'd1)) begin
                r_kpos <= 3'd0;
                r_rc   <= r_rc + 4'd1;
              end else begin
                r_kpos <= r_kpos + 3'd1;
              end
            end
          end
          ST_STREAM: begin
            if (key_ready) begin
              if (r_round == 4'd0) begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
                r_valid <= 1'b0;
                r_last  <= 1'b0;
              end else begin
                r_round <= w_next_round;
                r_key   <= w_next_key;
                r_last  <= (w_next_round == 4'd0);
              end
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign busy      = r_busy;
  assign err       = r_err;
  assign key_valid = r_valid;
  assign round_key = r_key;
  assign round_idx = r_round;
  assign last      = r_last;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_aes_inv_roundkey_gen.sv
module tb_aes_inv_roundkey_gen;

  // ---------------- clock / reset / DUTs ----------------
  logic         clk = 1'b0;
  logic         rst, start, key_ready;
  logic [1:0]   mode;
  logic [255:0] key_in;
  logic         busy0, err0, valid0, last0, busy1, err1, valid1, last1;
  logic [127:0] rk0, rk1;
  logic [3:0]   idx0, idx1;
  logic [1:0]   dbg0, dbg1;

  always #5 clk = ~clk;

  aes_inv_roundkey_gen #(.EQ_INV(1'b0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .key_in(key_in),
    .busy(busy0), .err(err0), .key_valid(valid0), .key_ready(key_ready),
    .round_key(rk0), .round_idx(idx0), .last(last0), .dbg_state(dbg0)
  );

  aes_inv_roundkey_gen #(.EQ_INV(1'b1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .key_in(key_in),
    .busy(busy1), .err(err1), .key_valid(valid1), .key_ready(key_ready),
    .round_key(rk1), .round_idx(idx1), .last(last1), .dbg_state(dbg1)
  );

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int           n_cmp = 0;
  int           n_err = 0;
  logic [131:0] exp_q0[$];   // {round, key} for raw output
  logic [131:0] exp_q1[$];   // {round, key} for equivalent-inverse output
  int           m_nkeys;
  logic [127:0] got0 [16];
  logic [127:0] got1 [16];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model (FIPS-197 arithmetic) ----------------
  logic [7:0] m_sbox [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p = 8'h00;
    aa = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      if (x != 0) begin
        inv = 8'h01;
        for (int e = 0; e < 254; e++) inv = gmul(inv, 8'(x));
      end
      m_sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_word_m(input logic [31:0] t);
    return {m_sbox[t[31:24]], m_sbox[t[23:16]], m_sbox[t[15:8]], m_sbox[t[7:0]]};
  endfunction

  function automatic logic [127:0] m_imc(input logic [127:0] s);
    logic [7:0] coef [4];
    logic [7:0] acc;
    logic [127:0] o;
    coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++) acc = acc ^ gmul(coef[(k - row) & 3], s[127-32*c-8*k -: 8]);
        o[127-32*c-8*row -: 8] = acc;
      end
    end
    return o;
  endfunction

  task automatic model_push(input logic [1:0] md, input logic [255:0] key);
    int nk, nr;
    logic [31:0]  w [60];
    logic [31:0]  t;
    logic [7:0]   rc;
    logic [127:0] rk;
    nk = 4 + 2 * int'(md);
    nr = nk + 6;
    for (int j = 0; j < nk; j++) w[j] = key[32*(nk-j)-1 -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        rc = 8'h01;
        for (int q = 1; q < i / nk; q++) rc = gmul(rc, 8'h02);
        t = sub_word_m({t[23:0], t[31:24]}) ^ {rc, 24'h0};
      end else if (nk == 8 && i % 8 == 4) begin
        t = sub_word_m(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = nr; r >= 0; r--) begin
      rk = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      exp_q0.push_back({4'(r), rk});
      exp_q1.push_back({4'(r), (r != 0 && r != nr) ? m_imc(rk) : rk});
    end
    m_nkeys = nr + 1;
  endtask

  // ---------------- drivers ----------------
  task automatic do_start(input logic [1:0] md, input logic [255:0] key);
    start  = 1'b1;
    mode   = md;
    key_in = key;
    @(posedge clk); #1;
    start  = 1'b0;
  endtask

  // Returns the number of clock edges from the start edge until key_valid is seen.
  task automatic start_and_wait(input logic [1:0] md, input logic [255:0] key,
                                output int cyc, output logic first_valid);
    do_start(md, key);
    cyc = 1;
    first_valid = valid0;
    while (!valid0 && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!valid0) check("wait_valid_timeout", 128'(valid0), 128'(1'b1));
  endtask

  task automatic stream_keys(input bit rand_ready, output int cycles, output int n_hs);
    logic [131:0] e0, e1;
    bit hs;
    cycles = 0;
    n_hs = 0;
    while (exp_q0.size() > 0 && cycles < 2000) begin
      if (valid0) begin
        e0 = exp_q0[0];
        e1 = exp_q1[0];
        check("key_raw",  rk0, e0[127:0]);
        check("idx_raw",  128'(idx0), 128'(e0[131:128]));
        check("last_raw", 128'(last0), 128'(e0[131:128] == 4'd0));
        check("valid_eq", 128'(valid1), 128'(1'b1));
        check("key_eq",   rk1, e1[127:0]);
        check("idx_eq",   128'(idx1), 128'(e1[131:128]));
        check("busy_strm", 128'(busy0), 128'(1'b1));
        got0[idx0] = rk0;
        got1[idx1] = rk1;
      end else if (!rand_ready) begin
        check("stream_gap", 128'(valid0), 128'(1'b1));
      end
      key_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      hs = valid0 && key_ready;
      @(posedge clk); #1;
      cycles++;
      if (hs) begin
        void'(exp_q0.pop_front());
        void'(exp_q1.pop_front());
        n_hs++;
      end
    end
    key_ready = 1'b0;
    check("stream_drained", 128'(exp_q0.size()), 128'(0));
    check("done_valid", 128'(valid0), 128'(1'b0));
    check("done_busy",  128'(busy0), 128'(1'b0));
    check("done_valid_eq", 128'(valid1), 128'(1'b0));
    exp_q0.delete();
    exp_q1.delete();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"},  128'({busy0, busy1}), 128'(0));
    check({tag, "_err"},   128'({err0, err1}), 128'(0));
    check({tag, "_valid"}, 128'({valid0, valid1}), 128'(0));
    check({tag, "_last"},  128'({last0, last1}), 128'(0));
    check({tag, "_idx"},   128'({idx0, idx1}), 128'(0));
    check({tag, "_key0"},  rk0, 128'h0);
    check({tag, "_key1"},  rk1, 128'h0);
  endtask

  // ---------------- test ----------------
  typedef struct {
    logic [1:0]   mode;
    logic [255:0] key;
    logic [127:0] first;
    int           lat;
  } vec_t;

  vec_t tbl [3];

  initial begin
    int cyc, ncyc, nhs;
    logic fv;
    logic [1:0]   md;
    logic [255:0] rkey;
    bit seen;

    tbl[0] = '{mode: 2'b00, key: 256'h2b7e151628aed2a6abf7158809cf4f3c,
               first: 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, lat: 42};
    tbl[1] = '{mode: 2'b01, key: 256'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b,
               first: 128'he98ba06f448c773c8ecc720401002202, lat: 48};
    tbl[2] = '{mode: 2'b10,
               key: 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4,
               first: 128'hfe4890d1e6188d0b046df344706c631e, lat: 54};

    rst = 1'b1; start = 1'b0; mode = 2'b00; key_in = '0; key_ready = 1'b0;
    build_sbox();
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Known-answer vectors; the AES-256 one uses random ready gaps.
    for (int v = 0; v < 3; v++) begin
      model_push(tbl[v].mode, tbl[v].key);
      start_and_wait(tbl[v].mode, tbl[v].key, cyc, fv);
      check("latency", 128'(cyc), 128'(tbl[v].lat));
      check("first_key", rk0, tbl[v].first);
      check("first_idx", 128'(idx0), 128'(10 + 2 * int'(tbl[v].mode)));
      stream_keys(v == 2, ncyc, nhs);
      check("n_keys", 128'(nhs), 128'(m_nkeys));
      if (v != 2) check("back_to_back", 128'(ncyc), 128'(m_nkeys));
      if (v == 0) begin
        check("r0_is_key", got0[0], tbl[0].key[127:0]);
        check("eq_r10_raw", got1[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        check("eq_r0_raw", got1[0], tbl[0].key[127:0]);
        check("eq_r9_imc", got1[9], m_imc(128'hac7766f319fadc2128d12941575c006e));
      end
    end

    // Random keys, modes and ready gaps.
    for (int n = 0; n < 6; n++) begin
      md = 2'($urandom_range(0, 2));
      rkey = {$urandom(), $urandom(), $urandom(), $urandom(),
              $urandom(), $urandom(), $urandom(), $urandom()};
      model_push(md, rkey);
      start_and_wait(md, rkey, cyc, fv);
      check("rand_latency", 128'(cyc), 128'(42 + 6 * int'(md)));
      stream_keys(1'b1, ncyc, nhs);
      check("rand_n_keys", 128'(nhs), 128'(m_nkeys));
    end

    // Illegal mode from idle: one err pulse, no job.
    do_start(2'b11, tbl[0].key);
    check("err_pulse", 128'({err0, err1}), 128'(2'b11));
    check("err_busy", 128'(busy0), 128'(1'b0));
    @(posedge clk); #1;
    check("err_one_cycle", 128'(err0), 128'(1'b0));
    seen = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (valid0 || busy0) seen = 1'b1;
      @(posedge clk); #1;
    end
    check("err_no_job", 128'(seen), 128'(1'b0));

    // Illegal-mode start while expanding: only the err pulse, job continues.
    model_push(tbl[0].mode, tbl[0].key);
    do_start(tbl[0].mode, tbl[0].key);
    repeat (5) @(posedge clk);
    #1;
    do_start(2'b11, tbl[2].key);
    check("err_busy_pulse", 128'(err0), 128'(1'b1));
    check("err_busy_kept", 128'(busy0), 128'(1'b1));
    cyc = 0;
    while (!valid0 && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
    end
    stream_keys(1'b0, ncyc, nhs);
    check("err_busy_n_keys", 128'(nhs), 128'(11));

    // Restart mid-stream with an AES-192 key while the consumer stalls.
    start_and_wait(tbl[0].mode, tbl[0].key, cyc, fv);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("stall_hold_key", rk0, tbl[0].first);
      check("stall_hold_idx", 128'(idx0), 128'(10));
    end
    model_push(tbl[1].mode, tbl[1].key);
    start_and_wait(tbl[1].mode, tbl[1].key, cyc, fv);
    check("restart_drop_valid", 128'(fv), 128'(1'b0));
    check("restart_latency", 128'(cyc), 128'(48));
    check("restart_first", rk0, tbl[1].first);
    stream_keys(1'b0, ncyc, nhs);

    // Reset during EXPAND.
    do_start(tbl[0].mode, tbl[0].key);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_vals("rst_expand");
    rst = 1'b0;
    @(posedge clk); #1;

    // Reset during STREAM, colliding with a handshake.
    start_and_wait(tbl[0].mode, tbl[0].key, cyc, fv);
    rst = 1'b1;
    key_ready = 1'b1;
    @(posedge clk); #1;
    check_reset_vals("rst_stream");
    rst = 1'b0;
    key_ready = 1'b0;
    @(posedge clk); #1;

    // After reset a fresh job behaves like the first vector.
    model_push(tbl[0].mode, tbl[0].key);
    start_and_wait(tbl[0].mode, tbl[0].key, cyc, fv);
    check("post_rst_latency", 128'(cyc), 128'(42));
    stream_keys(1'b0, ncyc, nhs);
    check("post_rst_n_keys", 128'(nhs), 128'(11));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
